// File: rtl/fifo_read_pointer_empty_if.sv
// Read-side bus of the async FIFO read pointer block.
// The slave modport is the pointer/empty logic; the master modport is the
// read consumer plus the write-pointer synchronizer feeding it.
interface fifo_read_pointer_empty_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  r_en_i;
  logic [ADDR_WIDTH:0]   r_w_ptr_i;
  logic [ADDR_WIDTH:0]   r_ptr_o;
  logic [ADDR_WIDTH-1:0] r_addr_o;
  logic                  r_empty_o;
  logic                  r_valid_o;
  logic                  r_underflow_o;
  logic [ADDR_WIDTH:0]   r_level_o;
  logic                  r_aempty_o;

  modport slave (
    input  r_en_i,
    input  r_w_ptr_i,
    output r_ptr_o,
    output r_addr_o,
    output r_empty_o,
    output r_valid_o,
    output r_underflow_o,
    output r_level_o,
    output r_aempty_o
  );

  modport master (
    output r_en_i,
    output r_w_ptr_i,
    input  r_ptr_o,
    input  r_addr_o,
    input  r_empty_o,
    input  r_valid_o,
    input  r_underflow_o,
    input  r_level_o,
    input  r_aempty_o
  );
endinterface

// File: rtl/fifo_read_pointer_empty.sv
// Read-side pointer and empty flag of the async FIFO (read clock domain only).
// Keeps a binary read pointer, publishes its Gray form for the write-domain
// synchronizer, drives the RAM read address and derives a registered empty flag
// from the already-synchronized Gray write pointer.
// Optional feature macro: FIFO_ALMOST_EMPTY_EN adds a registered fill level and
// almost-empty flag; without it the level reads 0 and almost-empty follows empty.
module fifo_read_pointer_empty #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_THRESH  = 1
) (
  input logic                       r_clk_i,
  input logic                       r_rst_i,
  fifo_read_pointer_empty_if.slave  rd_if
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gray_next;
  logic [PW-1:0] r_gray_q;
  logic          r_empty_q;
  logic          r_valid_q;
  logic          r_underflow_q;
  logic          rd;

  // A read is only accepted while the registered flag says data is present,
  // so the pointer can never run past the write pointer.
  always_comb begin
    rd          = rd_if.r_en_i & ~r_empty_q;
    r_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, rd};
    r_gray_next = (r_bin_next >> 1) ^ r_bin_next;
  end

  // Pointer, empty, valid and underflow all move together on the read clock;
  // reset wins over any read presented in the same cycle.
  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      r_bin         <= '0;
      r_gray_q      <= '0;
      r_empty_q     <= 1'b1;
      r_valid_q     <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      r_bin         <= r_bin_next;
      r_gray_q      <= r_gray_next;
      r_empty_q     <= (r_gray_next == rd_if.r_w_ptr_i);
      r_valid_q     <= rd;
      r_underflow_q <= rd_if.r_en_i & r_empty_q;
    end
  end

  assign rd_if.r_ptr_o       = r_gray_q;
  assign rd_if.r_addr_o      = r_bin[ADDR_WIDTH-1:0];
  assign rd_if.r_empty_o     = r_empty_q;
  assign rd_if.r_valid_o     = r_valid_q;
  assign rd_if.r_underflow_o = r_underflow_q;

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [PW-1:0] w_bin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] r_level_q;
  logic          r_aempty_q;

  // Gray-to-binary of the synchronized write pointer: each binary bit is the
  // XOR of all Gray bits at or above it; the level is then a plain difference.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < PW; i++) begin
      w_bin[i] = ^(rd_if.r_w_ptr_i >> i);
    end
    level_next = w_bin - r_bin_next;
  end

  // Level and almost-empty are registered alongside empty so all three agree.
  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      r_level_q  <= '0;
      r_aempty_q <= 1'b1;
    end else begin
      r_level_q  <= level_next;
      r_aempty_q <= (level_next <= PW'(AE_THRESH));
    end
  end

  assign rd_if.r_level_o  = r_level_q;
  assign rd_if.r_aempty_o = r_aempty_q;
`else
  assign rd_if.r_level_o  = '0;
  assign rd_if.r_aempty_o = r_empty_q;
`endif

endmodule
